// File: rtl/seg_scan_display_if.sv
// Bus between the countdown-timer commander and the 7-segment scan stage.
// The master side drives the BCD time fields, the edit-field select and the
// time-out flag; the slave side (the display stage) drives anodes, segments
// and the decimal point back out toward the display pins.
interface seg_scan_display_if;
    logic [7:0] min_i;
    logic [7:0] sec_i;
    logic [7:0] ms_10_i;
    logic [1:0] target;
    logic       time_out_i;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output min_i,
        output sec_i,
        output ms_10_i,
        output target,
        output time_out_i,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  min_i,
        input  sec_i,
        input  ms_10_i,
        input  target,
        input  time_out_i,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/seg_scan_display.sv
// Eight-digit common-anode 7-segment scanner for the countdown timer.
// Digits 0..5 show ms_10, sec and min (units then tens); digits 6 and 7 stay
// dark. The field being edited blinks, the whole display flashes on time-out,
// and every digit dwell begins with one all-dark cycle to suppress ghosting.
// Time fields are latched once per full frame so a frame never mixes old and
// new values.
module seg_scan_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk_core,
    input  logic              rst_n,
    seg_scan_display_if.slave bus
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [7:0] AN_DARK  = 8'hFF;
    localparam logic [6:0] SEG_DARK = 7'h7F;

    // Scan and blink timing state
    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         digit_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    // Frame holding registers for the three BCD fields
    logic [7:0] hold_min;
    logic [7:0] hold_sec;
    logic [7:0] hold_ms;

    // Decode helpers
    logic       scan_last;
    logic       frame_last;
    logic       blink_last;
    logic [3:0] nibble;
    logic       field_hit;
    logic       digit_lit;
    logic       show_digit;

    // Next values for the registered outputs
    logic [7:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    // Registered outputs
    logic [7:0] an_q;
    logic [6:0] seg_q;
    logic       dp_q;

    assign scan_last  = (scan_cnt == SCAN_LAST);
    assign frame_last = scan_last && (digit_idx == 3'd7);
    assign blink_last = (blink_cnt == BLINK_LAST);

    // Digit dwell counter; each terminal count moves the scan to the next digit
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (scan_last) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Free-running blink phase generator, independent of the scan and of edit state
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_last) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Latch the time fields only at the very end of a frame so digits never tear
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            hold_min <= 8'h00;
            hold_sec <= 8'h00;
            hold_ms  <= 8'h00;
        end else if (frame_last) begin
            hold_min <= bus.min_i;
            hold_sec <= bus.sec_i;
            hold_ms  <= bus.ms_10_i;
        end
    end

    // Pick the BCD nibble belonging to the digit currently being scanned
    always_comb begin
        nibble = 4'h0;
        case (digit_idx)
            3'd0:    nibble = hold_ms[3:0];
            3'd1:    nibble = hold_ms[7:4];
            3'd2:    nibble = hold_sec[3:0];
            3'd3:    nibble = hold_sec[7:4];
            3'd4:    nibble = hold_min[3:0];
            3'd5:    nibble = hold_min[7:4];
            default: nibble = 4'h0;
        endcase
    end

    // Visibility: unused digits, time-out flash, then edit-field blink, in priority order
    always_comb begin
        field_hit = (bus.target != 2'b11) && (digit_idx[2:1] == bus.target);
        digit_lit = 1'b1;
        if (digit_idx >= 3'd6) begin
            digit_lit = 1'b0;
        end else if (bus.time_out_i && !blink_on) begin
            digit_lit = 1'b0;
        end else if (field_hit && !blink_on) begin
            digit_lit = 1'b0;
        end
        show_digit = digit_lit && (scan_cnt != '0);
    end

    // Anode, segment and decimal-point values for the next output cycle
    always_comb begin
        an_next  = AN_DARK;
        seg_next = SEG_DARK;
        dp_next  = 1'b1;
        if (show_digit) begin
            an_next = ~(8'd1 << digit_idx);
            case (nibble)
                4'd0:    seg_next = 7'b1000000;
                4'd1:    seg_next = 7'b1111001;
                4'd2:    seg_next = 7'b0100100;
                4'd3:    seg_next = 7'b0110000;
                4'd4:    seg_next = 7'b0011001;
                4'd5:    seg_next = 7'b0010010;
                4'd6:    seg_next = 7'b0000010;
                4'd7:    seg_next = 7'b1111000;
                4'd8:    seg_next = 7'b0000000;
                4'd9:    seg_next = 7'b0010000;
                default: seg_next = 7'b0111111;
            endcase
            if ((digit_idx == 3'd2) || (digit_idx == 3'd4)) begin
                dp_next = 1'b0;
            end
        end
    end

    // Register the display pins so they are glitch-free toward the panel
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= AN_DARK;
            seg_q <= SEG_DARK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_next;
            seg_q <= seg_next;
            dp_q  <= dp_next;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with short scan and blink periods.
// A behavioural model derives the expected pins from the number of clock
// edges since reset (dwell position, digit and blink phase by division) and a
// frame-latched copy of the time fields.
module tb_seg_scan_display;

    localparam int SD = 4;
    localparam int BD = 64;

    logic clk_core = 1'b0;
    logic rst_n    = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model state
    int         n;
    int         loads;
    logic [7:0] h_min;
    logic [7:0] h_sec;
    logic [7:0] h_ms;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         m_idx;
    int         m_pos;
    logic       m_blink;

    seg_scan_display_if disp ();

    seg_scan_display #(
        .SCAN_DIV (SD),
        .BLINK_DIV(BD)
    ) dut (
        .clk_core(clk_core),
        .rst_n   (rst_n),
        .bus     (disp)
    );

    // Free-running core clock
    always #5 clk_core = ~clk_core;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic applyStimulus(input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] ms,
                                 input logic [1:0] tg, input logic to);
        disp.min_i      = mn;
        disp.sec_i      = sc;
        disp.ms_10_i    = ms;
        disp.target     = tg;
        disp.time_out_i = to;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge
    task automatic model_step();
        int         pos;
        int         idx;
        logic       blink;
        logic       lit;
        logic [7:0] fld;
        logic [3:0] nib;
        if (!rst_n) begin
            n = 0; loads = 0;
            h_min = 8'h00; h_sec = 8'h00; h_ms = 8'h00;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
            m_idx = 0; m_pos = 0; m_blink = 1'b1;
        end else begin
            pos   = n % SD;
            idx   = (n / SD) % 8;
            blink = ((n / BD) % 2) == 0;
            case (idx / 2)
                0:       fld = h_ms;
                1:       fld = h_sec;
                2:       fld = h_min;
                default: fld = 8'h00;
            endcase
            nib = (idx % 2 == 1) ? fld[7:4] : fld[3:0];
            lit = idx < 6;
            if (disp.time_out_i && !blink) lit = 1'b0;
            if (disp.target != 2'b11 && idx / 2 == int'(disp.target) && !blink) lit = 1'b0;
            m_idx = idx; m_pos = pos; m_blink = blink;
            if (pos != 0 && lit) begin
                exp_an  = ~(8'd1 << idx);
                exp_seg = decode(nib);
                exp_dp  = !(idx == 2 || idx == 4);
            end else begin
                exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end
            if (pos == SD - 1 && idx == 7) begin
                h_min = disp.min_i; h_sec = disp.sec_i; h_ms = disp.ms_10_i;
                loads++;
            end
            n++;
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(8'h00, 8'h00, 8'h00, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (disp.an !== 8'hFF || disp.seg !== 7'h7F || disp.dp !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_hold an=%h seg=%b dp=%b want an=ff seg=1111111 dp=1", disp.an, disp.seg, disp.dp);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (disp.an !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_first_blank an=%h want ff", disp.an);
        end
        tick();
        checks++;
        if (disp.an !== 8'hFE || disp.seg !== 7'b1000000 || disp.dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_digit0 an=%h seg=%b dp=%b want an=fe seg=1000000 dp=1", disp.an, disp.seg, disp.dp);
        end
    endtask

    task automatic test_normal_scan();
        int         l0;
        logic [6:0] nrm [6];
        nrm = '{7'b0010000, 7'b0010000, 7'b1000000, 7'b0110000, 7'b0010010, 7'b1000000};
        applyStimulus(8'h05, 8'h30, 8'h99, 2'b11, 1'b0);
        l0 = loads;
        for (int i = 0; i < 80 && loads == l0; i++) begin
            tick();
            checks++;
            if (disp.an !== exp_an || disp.dp !== exp_dp || (exp_an !== 8'hFF && disp.seg !== exp_seg)) begin
                errors++;
                $display("[TB] FAIL normal_wait an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", disp.an, disp.seg, disp.dp, exp_an, exp_seg, exp_dp);
            end
        end
        checks++;
        if (loads == l0) begin
            errors++;
            $display("[TB] FAIL normal_frame_timeout loads=%0d want >%0d", loads, l0);
        end
        for (int i = 0; i < 8 * SD; i++) begin
            tick();
            checks++;
            if (m_pos == 0 || m_idx >= 6) begin
                if (disp.an !== 8'hFF) begin
                    errors++;
                    $display("[TB] FAIL normal_dark idx=%0d pos=%0d an=%h want ff", m_idx, m_pos, disp.an);
                end
            end else if (disp.an !== ~(8'd1 << m_idx) || disp.seg !== nrm[m_idx] ||
                         disp.dp !== !(m_idx == 2 || m_idx == 4)) begin
                errors++;
                $display("[TB] FAIL normal_digit idx=%0d an=%h seg=%b dp=%b want seg=%b", m_idx, disp.an, disp.seg, disp.dp, nrm[m_idx]);
            end
        end
    endtask

    task automatic test_field_blink();
        logic seen_dark;
        logic seen_lit;
        seen_dark = 1'b0;
        seen_lit  = 1'b0;
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 2'b01, 1'b0);
        for (int i = 0; i < 3 * BD; i++) begin
            tick();
            checks++;
            if (disp.an !== exp_an || disp.dp !== exp_dp || (exp_an !== 8'hFF && disp.seg !== exp_seg)) begin
                errors++;
                $display("[TB] FAIL blink_model an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", disp.an, disp.seg, disp.dp, exp_an, exp_seg, exp_dp);
            end
            if (m_pos != 0 && m_idx < 6) begin
                checks++;
                if ((m_idx == 2 || m_idx == 3) && !m_blink) begin
                    seen_dark = 1'b1;
                    if (disp.an !== 8'hFF) begin
                        errors++;
                        $display("[TB] FAIL blink_sel_dark idx=%0d an=%h want ff", m_idx, disp.an);
                    end
                end else if (disp.an !== ~(8'd1 << m_idx)) begin
                    errors++;
                    $display("[TB] FAIL blink_lit idx=%0d an=%h want %h", m_idx, disp.an, ~(8'd1 << m_idx));
                end else if (m_idx == 2) begin
                    seen_lit = 1'b1;
                end
            end
        end
        checks++;
        if (!(seen_dark && seen_lit)) begin
            errors++;
            $display("[TB] FAIL blink_phases dark=%b lit=%b want 1 1", seen_dark, seen_lit);
        end
    endtask

    task automatic test_time_out();
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 2'b10, 1'b1);
        for (int i = 0; i < 3 * BD; i++) begin
            tick();
            checks++;
            if (disp.an !== exp_an || disp.dp !== exp_dp || (exp_an !== 8'hFF && disp.seg !== exp_seg)) begin
                errors++;
                $display("[TB] FAIL timeout_model an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", disp.an, disp.seg, disp.dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
            if (!m_blink && disp.an !== 8'hFF) begin
                errors++;
                $display("[TB] FAIL timeout_flash_off idx=%0d an=%h want ff", m_idx, disp.an);
            end else if (m_blink && m_pos != 0 && m_idx < 6 && disp.an !== ~(8'd1 << m_idx)) begin
                errors++;
                $display("[TB] FAIL timeout_flash_on idx=%0d an=%h want %h", m_idx, disp.an, ~(8'd1 << m_idx));
            end
        end
    endtask

    task automatic test_frame_coherence();
        int l0;
        int i;
        applyStimulus(8'h05, 8'h30, 8'h99, 2'b11, 1'b0);
        l0 = loads;
        for (i = 0; i < 80 && !(loads > l0 && m_idx == 3 && m_pos == 1); i++) tick();
        checks++;
        if (!(loads > l0 && m_idx == 3)) begin
            errors++;
            $display("[TB] FAIL frame_sync_timeout idx=%0d loads=%0d", m_idx, loads);
        end
        disp.sec_i = 8'h29;
        l0 = loads;
        for (i = 0; i < 16 * SD; i++) begin
            tick();
            if (m_pos != 0 && (m_idx == 2 || m_idx == 3)) begin
                checks++;
                if (loads == l0 && disp.seg !== (m_idx == 3 ? 7'b0110000 : 7'b1000000)) begin
                    errors++;
                    $display("[TB] FAIL frame_old idx=%0d seg=%b want old sec 30", m_idx, disp.seg);
                end else if (loads > l0 && disp.seg !== (m_idx == 3 ? 7'b0100100 : 7'b0010000)) begin
                    errors++;
                    $display("[TB] FAIL frame_new idx=%0d seg=%b want new sec 29", m_idx, disp.seg);
                end
            end
        end
        checks++;
        if (loads == l0) begin
            errors++;
            $display("[TB] FAIL frame_reload_timeout loads=%0d", loads);
        end
    endtask

    task automatic test_invalid_bcd();
        int l0;
        applyStimulus(8'h12, 8'h34, 8'hA7, 2'b11, 1'b0);
        l0 = loads;
        for (int i = 0; i < 80 && loads == l0; i++) tick();
        for (int i = 0; i < 8 * SD; i++) begin
            tick();
            checks++;
            if (disp.an !== exp_an || disp.dp !== exp_dp || (exp_an !== 8'hFF && disp.seg !== exp_seg)) begin
                errors++;
                $display("[TB] FAIL bcd_model an=%h seg=%b want an=%h seg=%b", disp.an, disp.seg, exp_an, exp_seg);
            end
            if (m_pos != 0 && m_idx < 2) begin
                checks++;
                if (disp.seg !== (m_idx == 0 ? 7'b1111000 : 7'b0111111)) begin
                    errors++;
                    $display("[TB] FAIL bcd_digit idx=%0d seg=%b want %b", m_idx, disp.seg, (m_idx == 0 ? 7'b1111000 : 7'b0111111));
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 2'b11, 1'b0);
        for (int i = 0; i < 13 + int'($urandom_range(0, 7)); i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (disp.an !== 8'hFF || disp.seg !== 7'h7F || disp.dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_dark an=%h seg=%b dp=%b want ff 1111111 1", disp.an, disp.seg, disp.dp);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (disp.an !== 8'hFE || disp.seg !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL midreset_resume an=%h seg=%b want fe 1000000", disp.an, disp.seg);
        end
        for (int i = 0; i < 10 * SD; i++) begin
            tick();
            checks++;
            if (disp.an !== exp_an || disp.dp !== exp_dp || (exp_an !== 8'hFF && disp.seg !== exp_seg)) begin
                errors++;
                $display("[TB] FAIL midreset_model an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", disp.an, disp.seg, disp.dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_scan();
        test_field_blink();
        test_time_out();
        test_frame_coherence();
        test_invalid_bcd();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream display stage for the countdown-timer commander.
- Consumes the commander's BCD minute, second and 10 ms fields, its field-select code and the time-out flag.
- Time-multiplexes them onto an 8-digit common-anode 7-segment display.
- Blinks the field being edited, flashes the whole display on time-out, and inserts a ghosting blank at each digit change.

Parameters:
- SCAN_DIV, 100000: clk_core cycles each digit is driven (digit dwell); must be ≥2.
- BLINK_DIV, 25000000: clk_core cycles per blink half-period.

Ports:
- clk_core  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- min_i  input  8  BCD minutes: [7:4] tens, [3:0] units.
- sec_i  input  8  BCD seconds.
- ms_10_i  input  8  BCD hundredths of a second.
- target  input  2  field under edit:
  - 00 = ms_10
  - 01 = sec
  - 10 = min
  - 11 = running, no field blinks.
- time_out_i  input  1  countdown expired.
- an  output  8  digit anodes, active-low; bit k drives digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset: clk_core rising edge, asynchronous active-low reset (rst_n).
  - While rst_n=0: an=8'hFF, seg=7'h7F, dp=1, scan_cnt=0, digit_idx=0, blink_cnt=0, blink_on=1.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1.
  - When scan_cnt==SCAN_DIV-1, scan_cnt clears and digit_idx increments, wrapping 7→0.
- Digit mapping:
  - idx0 = ms_10_i[3:0], idx1 = ms_10_i[7:4]
  - idx2 = sec_i[3:0], idx3 = sec_i[7:4]
  - idx4 = min_i[3:0], idx5 = min_i[7:4]
  - idx6 and idx7 are always dark.
- Field inputs are sampled into a holding register only when scan_cnt==SCAN_DIV-1 and digit_idx==7. The full 6-digit frame therefore never tears mid-scan.
- target and time_out_i are sampled every cycle.
- Blink generator:
  - blink_cnt counts 0..BLINK_DIV-1.
  - At the terminal count it clears and toggles blink_on.
  - Free-running; unaffected by target or time_out_i.
- Visibility of digit idx (evaluated on registered state):
  - Dark if idx ≥6.
  - Dark if time_out_i=1 and blink_on=0; this overrides target.
  - Otherwise dark if target≠11, idx belongs to the selected field, and blink_on=0.
  - Otherwise lit.
- Outputs are registered, one cycle latency from digit_idx/scan_cnt state.
  - When scan_cnt==0 (first cycle of each dwell): an=8'hFF (ghosting blank).
  - Else if the digit is lit: an has only bit digit_idx low, and seg = decoded nibble.
  - Else: an=8'hFF.
- Decoder (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble >9 shows a dash, 0111111.
- Decimal point:
  - dp=0 when idx2 or idx4 is driven and lit; it separates sec.ms and min.sec.
  - dp=1 otherwise.
- Reset mid-scan: all counters return to 0 and outputs go dark immediately. Scanning resumes at idx0 with blink_on=1.
- target change mid-blink: takes effect on the next cycle; no phase resynchronisation.
- Simultaneous scan and blink terminal counts: both advance independently in the same cycle.

Test Plan (all with SCAN_DIV=4, BLINK_DIV=64):
- Reset: hold rst_n=0 for 3 cycles, then release → an=FF, seg=7F, dp=1 throughout reset. After release, digit 0 is driven with an=11111110 from the second cycle of its dwell.
- Normal scan: min_i=8'h05, sec_i=8'h30, ms_10_i=8'h99, target=11 →
  - idx0: seg=0010000, an=FE
  - idx2: seg=1000000, dp=0
  - idx3: seg=0110000
  - idx4: seg=0010010, dp=0
  - idx5: seg=1000000
  - idx6/idx7: an=FF
  - Every dwell starts with one an=FF cycle.
- Field blink: target=01 → idx2/idx3 are dark while blink_on=0 and lit while blink_on=1. idx0, 1, 4, 5 stay lit in both phases.
- Time-out flash: time_out_i=1, target=10 → all 8 anodes FF during blink_on=0. During blink_on=1, all six digits are lit, including min.
- Frame coherence: change sec_i 8'h30→8'h29 while digit_idx=3 → the idx3 dwell still shows 3. The new value appears starting with the next frame's idx0.
- Invalid BCD: ms_10_i=8'hA7 → idx1 shows 0111111 (dash); idx0 shows 1111000 (7).
